packet_check: RTL

PACKET_CHECK -- requirements
Module: packet_check

---
 rtl/switch_pkg.sv | 47 ++++
 rtl/mac_to_port.sv | 21 ++
 rtl/packet_check.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: checker FSM states, metadata layout,
// header length and the per-port MAC table used by generator and checker.
package switch_pkg;

   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      TIME0,
      TIME1,
      SMAC0,
      SMAC1,
      PAYLOAD
   } state_t;

   localparam int HDR_WORDS    = 6;
   localparam int META_SRC_LSB = 30;
   localparam int META_DST_LSB = 28;
   localparam int META_LEN_LSB = 22;
   localparam int META_TS_LSB  = 0;

   localparam logic [47:0] PORT_MAC [0:3] = '{
      48'h02_00_5E_00_00_10,
      48'h02_00_5E_00_00_11,
      48'h02_00_5E_00_00_12,
      48'h02_00_5E_00_00_13
   };

   function automatic logic [47:0] port_to_mac(input logic [1:0] p);
      return PORT_MAC[p];
   endfunction

   function automatic logic [31:0] pack_meta(
      input logic [1:0]  src,
      input logic [1:0]  dst,
      input logic [5:0]  len,
      input logic [21:0] ts
   );
      logic [31:0] m;
      m = '0;
      m[META_SRC_LSB +: 2]  = src;
      m[META_DST_LSB +: 2]  = dst;
      m[META_LEN_LSB +: 6]  = len;
      m[META_TS_LSB  +: 22] = ts;
      return m;
   endfunction

endpackage

// File: rtl/mac_to_port.sv
// Combinational reverse lookup of a destination MAC to its switch port.
module mac_to_port
   import switch_pkg::*;
(
   input  logic [47:0] i_mac,
   output logic [1:0]  o_port,
   output logic        o_hit
);

   always_comb begin
      o_port = '0;
      o_hit  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i_mac == PORT_MAC[i]) begin
            o_port = 2'(i);
            o_hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/packet_check.sv
// Per-port packet checker: parses header/payload words, flags errors,
// reports metadata and latency once per packet, keeps saturating counters.
module packet_check
   import switch_pkg::*;
#(
   parameter logic [1:0] PORT      = 2'd0,
   parameter int         CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 packet_valid,
   input  logic [31:0]          packet,
   input  logic [21:0]          time_now,
   output logic                 meta_valid,
   output logic [31:0]          meta_out,
   output logic [21:0]          latency,
   output logic [3:0]           err,
   output logic [CNT_WIDTH-1:0] pkt_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   state_t r_state;
   state_t w_next;

   logic [5:0]  r_len;
   logic [5:0]  r_cnt;
   logic [15:0] r_dmac_hi;
   logic [1:0]  r_dst;
   logic [1:0]  r_src;
   logic [21:0] r_ts;
   logic [31:0] r_smac;
   logic [3:0]  r_err;

   logic                 r_meta_valid;
   logic [31:0]          r_meta_out;
   logic [21:0]          r_latency;
   logic [3:0]           r_err_out;
   logic [CNT_WIDTH-1:0] r_pkt_cnt;
   logic [CNT_WIDTH-1:0] r_err_cnt;

   logic [1:0] w_dst;
   logic       w_hit;
   logic [3:0] w_err_set;
   logic [3:0] w_err_all;
   logic       w_last;

   mac_to_port u_mac_to_port (
      .i_mac  ({r_dmac_hi, packet}),
      .o_port (w_dst),
      .o_hit  (w_hit)
   );

   assign w_last    = packet_valid && (r_state == PAYLOAD) && (r_cnt == 6'd0);
   assign w_err_all = r_err | w_err_set;

   // err bits: {hdr, mac, port, payload}
   always_comb begin
      w_err_set = '0;
      if (packet_valid) begin
         unique case (r_state)
            HDR0:    w_err_set[3] = (|packet[31:27]) | (|packet[20:16]);
            HDR1:    w_err_set[2:1] = {~w_hit, w_dst != PORT};
            TIME0:   w_err_set[3] = |packet[31:22];
            TIME1:   w_err_set[3] = |packet;
            SMAC0:   w_err_set[3] = |packet[31:2];
            SMAC1:   w_err_set[3] = (packet != r_smac) | (|packet[31:2]);
            PAYLOAD: w_err_set[0] = packet != 32'hFFFF_FFFF;
            default: w_err_set = '0;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      if (packet_valid) begin
         unique case (r_state)
            HDR0:    w_next = HDR1;
            HDR1:    w_next = TIME0;
            TIME0:   w_next = TIME1;
            TIME1:   w_next = SMAC0;
            SMAC0:   w_next = SMAC1;
            SMAC1:   w_next = PAYLOAD;
            PAYLOAD: w_next = (r_cnt == 6'd0) ? HDR0 : PAYLOAD;
            default: w_next = HDR0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= HDR0;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (packet_valid) begin
         r_err <= (r_state == HDR0) ? w_err_set : w_err_all;
         unique case (r_state)
            HDR0: begin
               r_len     <= packet[26:21];
               r_dmac_hi <= packet[15:0];
            end
            HDR1:    r_dst <= w_dst;
            TIME0:   r_ts  <= packet[21:0];
            SMAC0: begin
               r_src  <= packet[1:0];
               r_smac <= packet;
            end
            SMAC1:   r_cnt <= r_len;
            PAYLOAD: r_cnt <= r_cnt - 6'd1;
            default: ;
         endcase
      end
   end

   // Report registers load on the last payload word so they are valid with the pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta_valid <= 1'b0;
         r_meta_out   <= '0;
         r_latency    <= '0;
         r_err_out    <= '0;
         r_pkt_cnt    <= '0;
         r_err_cnt    <= '0;
      end else begin
         r_meta_valid <= w_last;
         if (w_last) begin
            r_meta_out <= pack_meta(r_src, r_dst, r_len, r_ts);
            r_latency  <= time_now - r_ts;
            r_err_out  <= w_err_all;
            if (!(&r_pkt_cnt))
               r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            if ((w_err_all != 4'd0) && !(&r_err_cnt))
               r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign meta_valid = r_meta_valid;
   assign meta_out   = r_meta_out;
   assign latency    = r_latency;
   assign err        = r_err_out;
   assign pkt_cnt    = r_pkt_cnt;
   assign err_cnt    = r_err_cnt;

endmodule
